// File: rtl/tq_row_scan_pkg.sv
// tq_row_scan_pkg: shared definitions for the tq row scanner.
//   COEF_W          default coefficient width (matches the mux data width)
//   SIZE_4..SIZE_32 encodings of the 2-bit transform size
//   state_t         scanner FSM states
//   size_len_m1()   last column index for a given size encoding
`timescale 1ns/1ps
package tq_row_scan_pkg;

   localparam int COEF_W = 16;

   localparam logic [1:0] SIZE_4  = 2'd0;
   localparam logic [1:0] SIZE_8  = 2'd1;
   localparam logic [1:0] SIZE_16 = 2'd2;
   localparam logic [1:0] SIZE_32 = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // (4 << size) - 1, written out so the result is exactly 5 bits wide.
   function automatic logic [4:0] size_len_m1(input logic [1:0] size);
      logic [4:0] r;
      case (size)
         SIZE_4:  r = 5'd3;
         SIZE_8:  r = 5'd7;
         SIZE_16: r = 5'd15;
         default: r = 5'd31;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tq_row_scan.sv
// tq_row_scan: walks one transform row through an external 32:1 coefficient
// mux and streams the coefficients to the quantizer.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   row_valid        upstream has a complete row on the mux inputs
//   row_size         0=4, 1=8, 2=16, 3=32 coefficients
//   row_ready        high only in IDLE; a row is taken when row_valid&&row_ready
//   mux_add          column address to the mux (the scan counter)
//   mux_coef         mux output for mux_add, same cycle
//   o_valid/o_ready  output handshake
//   o_coef, o_idx    coefficient and its column index
//   o_last           final coefficient of the row
//   o_nz_cnt         non-zero count of the row, non-zero only on o_last beats
//   dbg_state        current FSM state
//
// Handshake: a beat transfers on a rising edge where o_valid && o_ready are
// both high. While o_valid=1 and o_ready=0 every o_* output holds. o_valid
// never drops without a transfer.
`timescale 1ns/1ps
module tq_row_scan #(
   parameter int COEF_W = tq_row_scan_pkg::COEF_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         row_valid,
   input  logic [1:0]                   row_size,
   output logic                         row_ready,
   output logic [4:0]                   mux_add,
   input  logic signed [COEF_W-1:0]     mux_coef,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic signed [COEF_W-1:0]     o_coef,
   output logic [4:0]                   o_idx,
   output logic                         o_last,
   output logic [5:0]                   o_nz_cnt,
   output tq_row_scan_pkg::state_t      dbg_state
);
   import tq_row_scan_pkg::*;

   state_t     state;
   logic [4:0] cnt;
   logic [4:0] len_m1;
   logic [5:0] nz_acc;

   logic       load;
   logic       is_last;
   logic [5:0] nz_next;

   // The output register may take a new coefficient when it is empty or its
   // current beat is leaving this cycle.
   assign load    = (state == SCAN) && (!o_valid || o_ready);
   assign is_last = (cnt == len_m1);
   assign nz_next = nz_acc + {5'd0, (mux_coef != '0)};

   assign mux_add   = cnt;
   assign row_ready = (state == IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 5'd0;
         len_m1   <= 5'd0;
         nz_acc   <= 6'd0;
         o_valid  <= 1'b0;
         o_coef   <= '0;
         o_idx    <= 5'd0;
         o_last   <= 1'b0;
         o_nz_cnt <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               // A stalled last beat of the previous row may still sit in the
               // output register; it drains below while the new row waits.
               if (row_valid) begin
                  len_m1 <= size_len_m1(row_size);
                  cnt    <= 5'd0;
                  nz_acc <= 6'd0;
                  state  <= SCAN;
               end
            end
            SCAN: begin
               if (load) begin
                  nz_acc <= nz_next;
                  if (is_last) begin
                     cnt   <= 5'd0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (load) begin
            o_coef   <= mux_coef;
            o_idx    <= cnt;
            o_last   <= is_last;
            o_nz_cnt <= is_last ? nz_next : 6'd0;
            o_valid  <= 1'b1;
         end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tq_row_scan.sv
`timescale 1ns/1ps
module tb_tq_row_scan;
   import tq_row_scan_pkg::*;

   localparam int W  = 16;
   localparam int BW = 1 + 6 + 5 + W;   // {last, nz_cnt, idx, coef}

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          row_valid;
   logic [1:0]    row_size;
   logic          row_ready;
   logic [4:0]    mux_add;
   logic signed [W-1:0] mux_coef;
   logic          o_valid;
   logic          o_ready;
   logic signed [W-1:0] o_coef;
   logic [4:0]    o_idx;
   logic          o_last;
   logic [5:0]    o_nz_cnt;
   state_t        dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Upstream row buffer plus the external 32:1 mux.
   logic [W-1:0] row_mem [32];
   assign mux_coef = row_mem[mux_add];

   tq_row_scan #(.COEF_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .row_valid(row_valid), .row_size(row_size), .row_ready(row_ready),
      .mux_add(mux_add), .mux_coef(mux_coef),
      .o_valid(o_valid), .o_ready(o_ready),
      .o_coef(o_coef), .o_idx(o_idx), .o_last(o_last), .o_nz_cnt(o_nz_cnt),
      .dbg_state(dbg_state)
   );

   // ---------------- counters / scoreboard ----------------
   int vectors = 0;
   int miscompares = 0;

   logic [BW-1:0] exp_q[$];
   int  nz_log[$];
   int  acc_log[$];
   int  last_beat_cyc = 0;
   bit  last_acc_stalled = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: a row of N coefficients yields N beats with ascending index; the
   // last carries the count of non-zero entries, the others carry zero.
   function automatic void push_row(input logic [1:0] size);
      int n;
      int nz;
      logic [BW-1:0] b;
      n  = 4 << size;
      nz = 0;
      for (int i = 0; i < n; i++) if (row_mem[i] != '0) nz++;
      for (int i = 0; i < n; i++) begin
         b = {(i == n - 1), ((i == n - 1) ? nz[5:0] : 6'd0), i[4:0], row_mem[i]};
         exp_q.push_back(b);
      end
   endfunction

   // ---------------- compare / monitor ----------------
   bit            stall_prev = 0;
   logic [BW-1:0] held;

   always @(negedge clk) begin
      logic [BW-1:0] got, e;
      if (!rst_n) begin
         stall_prev = 0;
      end else begin
         got = {o_last, o_nz_cnt, o_idx, o_coef};
         if (stall_prev) begin
            vectors++;
            if (!o_valid || got !== held) begin
               miscompares++;
               $display("FAIL hold: got valid=%0b beat=%h expected valid=1 beat=%h", o_valid, got, held);
            end
         end
         if (o_valid && o_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL beat: got unexpected beat idx=%0d expected none", o_idx);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  miscompares++;
                  $display("FAIL beat: got last=%0b nz=%0d idx=%0d coef=%0d expected last=%0b nz=%0d idx=%0d coef=%0d",
                           o_last, o_nz_cnt, o_idx, o_coef,
                           e[BW-1], e[BW-2:BW-7], e[W+4:W], $signed(e[W-1:0]));
               end
            end
            if (o_last) begin
               nz_log.push_back(int'(o_nz_cnt));
               last_beat_cyc = cyc;
            end
            stall_prev = 0;
         end else if (o_valid) begin
            held       = got;
            stall_prev = 1;
         end else begin
            stall_prev = 0;
         end
         // Row acceptance feeds the model.
         if (row_valid && row_ready) begin
            push_row(row_size);
            acc_log.push_back(cyc);
            last_acc_stalled = o_valid && o_last && !o_ready;
         end
      end
   end

   // ---------------- o_ready driver ----------------
   // 0: always ready; 1: ready one cycle in three; 3: stall each last beat 3 cycles
   int ready_mode = 0;
   initial begin
      int stalled;
      stalled = 0;
      o_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            1: o_ready = (cyc % 3 == 0);
            3: begin
               if (o_valid && o_last && stalled < 3) begin
                  o_ready = 1'b0;
                  stalled++;
               end else begin
                  o_ready = 1'b1;
                  if (!(o_valid && o_last)) stalled = 0;
               end
            end
            default: o_ready = 1'b1;
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   // Call #1 after a rising edge; returns the cycle in which the row was taken.
   task automatic send_row(input logic [1:0] size, output int t_acc);
      bit ok;
      ok = 0;
      row_size  = size;
      row_valid = 1'b1;
      t_acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (row_ready) begin ok = 1; t_acc = cyc; break; end
      end
      if (!ok) chk("row_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      row_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && row_ready && !o_valid) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", exp_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t, tv, tr;
      bit ok;
      rst_n = 1'b0; row_valid = 1'b0; row_size = 2'd0;
      for (int i = 0; i < 32; i++) row_mem[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_o_valid",  o_valid,  0);
      chk("rst_o_coef",   o_coef,   0);
      chk("rst_o_idx",    o_idx,    0);
      chk("rst_o_last",   o_last,   0);
      chk("rst_o_nz_cnt", o_nz_cnt, 0);
      chk("rst_mux_add",  mux_add,  0);
      chk("rst_state",    dbg_state, IDLE);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_row_ready", row_ready, 1);
      @(posedge clk); #1;

      // Size 4 {5,0,-3,0}, latency and turnaround.
      row_mem[0] = 16'd5; row_mem[1] = 16'd0; row_mem[2] = -16'sd3; row_mem[3] = 16'd0;
      nz_log.delete();
      send_row(SIZE_4, t);
      ok = 0; tv = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_valid) begin ok = 1; tv = cyc; break; end
      end
      chk("s4_first_valid_cyc", tv - t, 2);
      tr = -1;
      for (int i = 0; i < 10; i++) begin
         if (row_ready) begin tr = cyc; break; end
         @(negedge clk);
      end
      chk("s4_row_ready_cyc", tr - t, 5);
      wait_done();
      chk("s4_nz_rows", nz_log.size(), 1);
      if (nz_log.size() > 0) chk("s4_nz", nz_log[0], 2);

      // Size 32, all -1.
      for (int i = 0; i < 32; i++) row_mem[i] = 16'hFFFF;
      nz_log.delete();
      send_row(SIZE_32, t);
      wait_done();
      chk("s32_last_beat_cyc", last_beat_cyc - t, 33);
      if (nz_log.size() > 0) chk("s32_nz", nz_log[0], 32);
      else chk("s32_nz_rows", 0, 1);

      // Size 8 under a 1,0,0 ready pattern.
      for (int i = 0; i < 8; i++) row_mem[i] = 16'(i + 100);
      nz_log.delete();
      ready_mode = 1;
      send_row(SIZE_8, t);
      wait_done();
      ready_mode = 0;
      if (nz_log.size() > 0) chk("s8_nz", nz_log[0], 8);
      else chk("s8_nz_rows", 0, 1);

      // Back-to-back: zero size-16 row with a stalled last beat, then {1,2,3,4}.
      for (int i = 0; i < 32; i++) row_mem[i] = '0;
      nz_log.delete();
      ready_mode = 3;
      send_row(SIZE_16, t);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (row_ready) begin ok = 1; break; end
      end
      chk("b2b_ready_rise", ok, 1);
      row_mem[0] = 16'd1; row_mem[1] = 16'd2; row_mem[2] = 16'd3; row_mem[3] = 16'd4;
      send_row(SIZE_4, tv);
      chk("b2b_accept_cyc", tv - t, 17);
      chk("b2b_accept_while_stalled", last_acc_stalled, 1);
      wait_done();
      ready_mode = 0;
      chk("b2b_nz_rows", nz_log.size(), 2);
      if (nz_log.size() == 2) begin
         chk("b2b_nz_first", nz_log[0], 0);
         chk("b2b_nz_second", nz_log[1], 4);
      end

      // Asynchronous reset during beat 9 of a size-16 row, then resend.
      for (int i = 0; i < 16; i++) row_mem[i] = 16'(i - 8);
      send_row(SIZE_16, t);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_valid && o_idx == 5'd9) begin ok = 1; break; end
      end
      chk("rst_mid_reach_idx9", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_o_valid",  o_valid,  0);
      chk("mid_rst_o_coef",   o_coef,   0);
      chk("mid_rst_o_idx",    o_idx,    0);
      chk("mid_rst_o_last",   o_last,   0);
      chk("mid_rst_o_nz_cnt", o_nz_cnt, 0);
      chk("mid_rst_mux_add",  mux_add,  0);
      chk("mid_rst_state",    dbg_state, IDLE);
      @(negedge clk); #3 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_row_ready", row_ready, 1);
      @(posedge clk); #1;
      nz_log.delete();
      send_row(SIZE_16, t);
      wait_done();
      if (nz_log.size() > 0) chk("resend_nz", nz_log[0], 15);
      else chk("resend_nz_rows", 0, 1);

      // row_valid held high across a size-8 scan.
      for (int i = 0; i < 8; i++) row_mem[i] = 16'(i * 3);
      acc_log.delete();
      nz_log.delete();
      row_size  = SIZE_8;
      row_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (acc_log.size() >= 2) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      row_valid = 1'b0;
      chk("hold_two_accepts", ok, 1);
      if (acc_log.size() >= 2) chk("hold_accept_gap", acc_log[1] - acc_log[0], 9);
      wait_done();
      chk("hold_accept_count", acc_log.size(), 2);
      chk("hold_nz_rows", nz_log.size(), 2);
      if (nz_log.size() == 2) begin
         chk("hold_nz_a", nz_log[0], 7);
         chk("hold_nz_b", nz_log[1], 7);
      end

      chk("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
